display_bin7: RTL and testbench

Sequential back-end for the 7-bit LED result word (S6..S0) of the switch-to-binary stage. It synchronises the word, converts it to three BCD digits with a multi-cycle shift-add-3 (double-dabble) engine, and drives a 3-digit multiplexed common-anode seven-segment display with leading-zero blanking. It sits directly downstream of the combinational converter and directly drives the board pins.

---
 rtl/display_bin7_pkg.sv | 64 ++++++
 rtl/display_bin7_bin7_to_bcd.sv | 87 ++++++++
 rtl/display_bin7.sv | 94 +++++++++
 tb/tb_display_bin7.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/display_bin7_pkg.sv
// Shared types, segment codes and helpers for the 7-bit binary to 3-digit display back-end.
package display_bin7_pkg;

   localparam int unsigned BIN_W   = 7;
   localparam int unsigned BCD_W   = 4;
   localparam int unsigned SR_W    = BIN_W + 3 * BCD_W;
   localparam int unsigned CNT_W   = 3;
   localparam int unsigned SHIFTS  = BIN_W;
   localparam int unsigned SEG_W   = 7;
   localparam int unsigned DIGITS  = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Active-low segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h10;

   // Decimal digit to segment pattern; codes 10-15 are unreachable and show blank.
   function automatic logic [SEG_W-1:0] seg_of(input logic [BCD_W-1:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
   function automatic logic [SR_W-1:0] dd_adjust(input logic [SR_W-1:0] r);
      logic [SR_W-1:0] a;
      logic [BCD_W-1:0] nib;
      a = r;
      for (int i = 0; i < int'(DIGITS); i++) begin
         nib = r[BIN_W + i*BCD_W +: BCD_W];
         if (nib >= 4'd5) begin
            a[BIN_W + i*BCD_W +: BCD_W] = BCD_W'(nib + 4'd3);
         end
      end
      return a;
   endfunction

endpackage

// File: rtl/display_bin7_bin7_to_bcd.sv
// Multi-cycle shift-add-3 converter from a 7-bit value to committed hundreds/tens/ones digits.
module bin7_to_bcd
   import display_bin7_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] value,
   output logic       busy,
   output logic [3:0] bcd_h,
   output logic [3:0] bcd_t,
   output logic [3:0] bcd_o
);

   state_t            state_q, state_d;
   logic [SR_W-1:0]   sr_q, sr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BIN_W-1:0]  last_q, last_d;
   logic              busy_d;
   logic [BCD_W-1:0]  bcd_h_d, bcd_t_d, bcd_o_d;
   logic [SR_W-1:0]   sr_adj;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         last_q  <= '0;
         busy    <= 1'b0;
         bcd_h   <= '0;
         bcd_t   <= '0;
         bcd_o   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         busy    <= busy_d;
         bcd_h   <= bcd_h_d;
         bcd_t   <= bcd_t_d;
         bcd_o   <= bcd_o_d;
      end
   end

   assign sr_adj = dd_adjust(sr_q);

   // Any value differing from the last captured one restarts conversion once back in IDLE.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      busy_d  = busy;
      bcd_h_d = bcd_h;
      bcd_t_d = bcd_t;
      bcd_o_d = bcd_o;
      case (state_q)
         ST_IDLE: begin
            if (value != last_q) begin
               sr_d    = {12'b0, value};
               last_d  = value;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sr_d  = {sr_adj[SR_W-2:0], 1'b0};
            cnt_d = CNT_W'(cnt_q + 3'd1);
            if (cnt_q == CNT_W'(SHIFTS - 1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            bcd_h_d = sr_q[18:15];
            bcd_t_d = sr_q[14:11];
            bcd_o_d = sr_q[10:7];
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/display_bin7.sv
// Synchronises the LED result word, converts it to BCD and scans a 3-digit common-anode display.
module display_bin7
   import display_bin7_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] bin_in,
   output logic       busy,
   output logic [3:0] bcd_h,
   output logic [3:0] bcd_t,
   output logic [3:0] bcd_o,
   output logic [6:0] seg,
   output logic [2:0] an
);

   localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [BIN_W-1:0]  sync_meta, sync_val;
   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        idx;
   logic [SEG_W-1:0]  seg_c;
   logic [2:0]        an_c;

   // Two-flop synchroniser for the asynchronous switch word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= '0;
         sync_val  <= '0;
      end else begin
         sync_meta <= bin_in;
         sync_val  <= sync_meta;
      end
   end

   bin7_to_bcd u_conv (
      .clk   (clk),
      .rst_n (rst_n),
      .value (sync_val),
      .busy  (busy),
      .bcd_h (bcd_h),
      .bcd_t (bcd_t),
      .bcd_o (bcd_o)
   );

   // Digit-slot timer; idx walks ones -> tens -> hundreds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         idx      <= 2'd0;
      end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         idx      <= (idx == 2'd2) ? 2'd0 : 2'(idx + 2'd1);
      end else begin
         scan_cnt <= SCAN_W'(scan_cnt + SCAN_W'(1));
      end
   end

   // Leading-zero blanking: tens only blank when hundreds is also zero
   always_comb begin
      seg_c = SEG_BLANK;
      an_c  = 3'b111;
      case (idx)
         2'd0: begin
            an_c  = 3'b110;
            seg_c = seg_of(bcd_o);
         end
         2'd1: begin
            an_c  = 3'b101;
            seg_c = (bcd_h == 4'd0 && bcd_t == 4'd0) ? SEG_BLANK : seg_of(bcd_t);
         end
         2'd2: begin
            an_c  = 3'b011;
            seg_c = (bcd_h == 4'd0) ? SEG_BLANK : seg_of(bcd_h);
         end
         default: begin
            an_c  = 3'b111;
            seg_c = SEG_BLANK;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_BLANK;
         an  <= 3'b111;
      end else begin
         seg <= seg_c;
         an  <= an_c;
      end
   end

endmodule

// File: tb/tb_display_bin7.sv
// Directed bench for display_bin7 with a short scan period.
module tb_display_bin7;

   localparam int unsigned SCAN_DIV = 4;

   logic       clk;
   logic       rst_n;
   logic [6:0] bin_in;
   logic       busy;
   logic [3:0] bcd_h, bcd_t, bcd_o;
   logic [6:0] seg;
   logic [2:0] an;

   int checks   = 0;
   int failures = 0;

   display_bin7 #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bin_in (bin_in),
      .busy   (busy),
      .bcd_h  (bcd_h),
      .bcd_t  (bcd_t),
      .bcd_o  (bcd_o),
      .seg    (seg),
      .an     (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait for a fresh visit of a digit slot, then check its segment pattern.
   task automatic check_slot(input string tag, input logic [2:0] an_val, input logic [6:0] exp_seg);
      int n;
      n = 0;
      @(negedge clk);
      while (an === an_val && n < 40) begin
         @(negedge clk);
         n++;
      end
      while (an !== an_val && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         chk({tag, "_timeout"}, 32'(an), 32'(an_val));
      end else begin
         chk(tag, 32'(seg), 32'(exp_seg));
      end
   endtask

   function automatic logic [31:0] digits();
      return 32'({bcd_h, bcd_t, bcd_o});
   endfunction

   initial begin
      int n;
      rst_n  = 1'b0;
      bin_in = 7'd0;

      // Reset with zero input
      repeat (3) @(negedge clk);
      chk("rst_an",   32'(an),   32'h7);
      chk("rst_seg",  32'(seg),  32'h7F);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_bcd",  digits(),  32'h000);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_an",  32'(an),  32'h6);
      chk("rel_seg", 32'(seg), 32'h40);
      check_slot("zero_tens", 3'b101, 7'h7F);
      check_slot("zero_hund", 3'b011, 7'h7F);
      check_slot("zero_ones", 3'b110, 7'h40);

      // Full-scale value: capture at edge 2, commit at edge 10
      @(negedge clk);
      bin_in = 7'd127;
      for (int k = 0; k <= 11; k++) begin
         @(posedge clk); #1;
         chk($sformatf("fs_busy_e%0d", k), 32'(busy), (k >= 2 && k <= 9) ? 32'h1 : 32'h0);
         if (k == 9)  chk("fs_bcd_e9",  digits(), 32'h000);
         if (k == 10) chk("fs_bcd_e10", digits(), 32'h127);
      end
      check_slot("fs_hund", 3'b011, 7'h79);
      check_slot("fs_tens", 3'b101, 7'h24);
      check_slot("fs_ones", 3'b110, 7'h78);

      // Change during the 4th shift: 42 commits first, then 99 wins
      @(negedge clk);
      bin_in = 7'd42;
      for (int k = 0; k <= 24; k++) begin
         @(posedge clk); #1;
         chk($sformatf("mid_bcd_e%0d", k), digits(),
             (k < 10) ? 32'h127 : (k < 19) ? 32'h042 : 32'h099);
         if (k == 5) begin
            @(negedge clk);
            bin_in = 7'd99;
         end
      end

      // Blanking of leading zeros
      @(negedge clk);
      bin_in = 7'd5;
      repeat (12) @(posedge clk);
      #1;
      chk("b5_bcd", digits(), 32'h005);
      check_slot("b5_hund", 3'b011, 7'h7F);
      check_slot("b5_tens", 3'b101, 7'h7F);
      check_slot("b5_ones", 3'b110, 7'h12);

      @(negedge clk);
      bin_in = 7'd100;
      repeat (12) @(posedge clk);
      #1;
      chk("b100_bcd", digits(), 32'h100);
      check_slot("b100_hund", 3'b011, 7'h79);
      check_slot("b100_tens", 3'b101, 7'h40);
      check_slot("b100_ones", 3'b110, 7'h40);

      // Asynchronous reset in the middle of a conversion
      @(negedge clk);
      bin_in = 7'd64;
      repeat (6) @(posedge clk);
      #1;
      chk("mr_busy_pre", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mr_an",   32'(an),   32'h7);
      chk("mr_seg",  32'(seg),  32'h7F);
      chk("mr_busy", 32'(busy), 32'h0);
      chk("mr_bcd",  digits(),  32'h000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            chk("mr_rel_an",  32'(an),  32'h6);
            chk("mr_rel_seg", 32'(seg), 32'h40);
         end
         if (k == 9)  chk("mr_bcd_e9",  digits(), 32'h000);
         if (k == 10) chk("mr_bcd_e10", digits(), 32'h064);
      end

      // Scan cadence while a conversion runs
      @(negedge clk);
      bin_in = 7'd77;
      n = 0;
      while (an === 3'b110 && n < 40) begin
         @(negedge clk);
         n++;
      end
      while (an !== 3'b110 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         chk("cad_sync_timeout", 32'(an), 32'h6);
      end else begin
         for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            chk($sformatf("cad_an_%0d", j), 32'(an),
                (j < 4) ? 32'h6 : (j < 8) ? 32'h5 : (j < 12) ? 32'h3 : 32'h6);
         end
      end
      repeat (4) @(negedge clk);
      chk("cad_bcd", digits(), 32'h077);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
